// File: rtl/mmu_pkg.sv
// Shared types and constants for the data-side MMU translation stage.
// Holds exception codes, cache attribute encodings, segment bases, the
// translation FSM state type and the micro-TLB entry payload.
package mmu_pkg;

  localparam int unsigned VA_W   = 32;
  localparam int unsigned VPN_W  = 20;
  localparam int unsigned PFN_W  = 20;
  localparam int unsigned ASID_W = 8;
  localparam int unsigned CCA_W  = 3;
  localparam int unsigned EXC_W  = 5;
  localparam int unsigned SEG_W  = 3;

  localparam logic [EXC_W-1:0] EXC_MOD  = 5'd1;
  localparam logic [EXC_W-1:0] EXC_TLBL = 5'd2;
  localparam logic [EXC_W-1:0] EXC_TLBS = 5'd3;
  localparam logic [EXC_W-1:0] EXC_ADEL = 5'd4;
  localparam logic [EXC_W-1:0] EXC_ADES = 5'd5;

  localparam logic [CCA_W-1:0] CCA_UNCACHED = 3'd2;

  // Top three vaddr bits selecting the unmapped kernel segments.
  localparam logic [SEG_W-1:0] SEG_KSEG0 = 3'b100;
  localparam logic [SEG_W-1:0] SEG_KSEG1 = 3'b101;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOOKUP = 2'd1,
    RESP   = 2'd2
  } state_t;

  typedef struct packed {
    logic              valid;
    logic [VPN_W-1:0]  vpn;
    logic [ASID_W-1:0] asid;
    logic              g;
    logic [PFN_W-1:0]  pfn;
    logic              d;
    logic [CCA_W-1:0]  c;
  } utlb_entry_t;

endpackage

// File: rtl/utlb_array.sv
// Micro-TLB: small fully associative array of recent translations.
// Ports: clk/rst; flush clears all entries and the replacement pointer;
// lookup_vpn/lookup_asid drive a combinational match (hit_*_c);
// install writes install_entry at the round-robin pointer.
module utlb_array
  import mmu_pkg::*;
#(
  parameter int unsigned ENTRIES = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic [VPN_W-1:0]  lookup_vpn,
  input  logic [ASID_W-1:0] lookup_asid,
  output logic              hit_c,
  output logic [PFN_W-1:0]  hit_pfn_c,
  output logic              hit_d_c,
  output logic [CCA_W-1:0]  hit_cca_c,
  input  logic              install,
  input  utlb_entry_t       install_entry
);

  localparam int unsigned PTR_W = $clog2(ENTRIES);

  utlb_entry_t      entries [ENTRIES];
  logic [PTR_W-1:0] ptr;

  // Flush has priority over a same-cycle install; pointer wraps naturally
  // because ENTRIES is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(ENTRIES); i++) entries[i] <= '0;
      ptr <= '0;
    end else if (flush) begin
      for (int i = 0; i < int'(ENTRIES); i++) entries[i].valid <= 1'b0;
      ptr <= '0;
    end else if (install) begin
      entries[ptr] <= install_entry;
      ptr          <= ptr + PTR_W'(1);
    end
  end

  // Associative match; scanning downwards makes the lowest index win.
  always_comb begin
    hit_c     = 1'b0;
    hit_pfn_c = '0;
    hit_d_c   = 1'b0;
    hit_cca_c = '0;
    for (int i = int'(ENTRIES) - 1; i >= 0; i--) begin
      if (entries[i].valid && (entries[i].vpn == lookup_vpn) &&
          (entries[i].g || (entries[i].asid == lookup_asid))) begin
        hit_c     = 1'b1;
        hit_pfn_c = entries[i].pfn;
        hit_d_c   = entries[i].d;
        hit_cca_c = entries[i].c;
      end
    end
  end

endmodule

// File: rtl/dmmu_xlate.sv
// Data-side address translation stage between the memory stage and dcache.
// Ports: req_* handshake carries vaddr/store with user_mode, asid, k0_cca
// sampled at accept; rsp_* handshake returns paddr, CCA and exception info;
// tlb_vaddr/tlb_* form a one-cycle lookup against the joint TLB;
// tlb_flush invalidates the micro-TLB after a TLB write.
module dmmu_xlate
  import mmu_pkg::*;
#(
  parameter int unsigned UTLB_ENTRIES = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [VA_W-1:0]   req_vaddr,
  input  logic              req_store,
  input  logic              user_mode,
  input  logic [ASID_W-1:0] asid,
  input  logic [CCA_W-1:0]  k0_cca,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [VA_W-1:0]   rsp_paddr,
  output logic [CCA_W-1:0]  rsp_cache,
  output logic              rsp_exc,
  output logic [EXC_W-1:0]  rsp_exccode,
  output logic              rsp_refill,
  output logic [VA_W-1:0]   rsp_badvaddr,
  output logic [VA_W-1:0]   tlb_vaddr,
  input  logic              tlb_hit,
  input  logic [VA_W-1:0]   tlb_paddr,
  input  logic              tlb_v,
  input  logic              tlb_d,
  input  logic [CCA_W-1:0]  tlb_c,
  input  logic              tlb_flush
);

  state_t            state;
  logic              store_q;
  logic [ASID_W-1:0] asid_q;

  logic              flush;
  logic              install;
  utlb_entry_t       install_entry;
  logic              utlb_hit;
  logic [PFN_W-1:0]  utlb_pfn;
  logic              utlb_d;
  logic [CCA_W-1:0]  utlb_cca;

  // Any ASID change makes cached translations stale.
  assign flush   = tlb_flush | (asid != asid_q);
  // Only valid translations are cached; Mod results still install with D=0.
  assign install = (state == LOOKUP) & tlb_hit & tlb_v;

  // tlb_vaddr holds the latched request address during LOOKUP.
  always_comb begin
    install_entry       = '0;
    install_entry.valid = 1'b1;
    install_entry.vpn   = tlb_vaddr[VA_W-1:VA_W-VPN_W];
    install_entry.asid  = asid;
    install_entry.g     = 1'b0;
    install_entry.pfn   = tlb_paddr[VA_W-1:VA_W-PFN_W];
    install_entry.d     = tlb_d;
    install_entry.c     = tlb_c;
  end

  utlb_array #(
    .ENTRIES(UTLB_ENTRIES)
  ) u_utlb (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .lookup_vpn   (req_vaddr[VA_W-1:VA_W-VPN_W]),
    .lookup_asid  (asid),
    .hit_c        (utlb_hit),
    .hit_pfn_c    (utlb_pfn),
    .hit_d_c      (utlb_d),
    .hit_cca_c    (utlb_cca),
    .install      (install),
    .install_entry(install_entry)
  );

  // Translation FSM with registered handshake and response outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      req_ready    <= 1'b1;
      rsp_valid    <= 1'b0;
      rsp_paddr    <= '0;
      rsp_cache    <= '0;
      rsp_exc      <= 1'b0;
      rsp_exccode  <= '0;
      rsp_refill   <= 1'b0;
      rsp_badvaddr <= '0;
      tlb_vaddr    <= '0;
      store_q      <= 1'b0;
      asid_q       <= '0;
    end else begin
      asid_q <= asid;
      case (state)
        IDLE: begin
          if (req_valid) begin
            store_q      <= req_store;
            rsp_badvaddr <= req_vaddr;
            rsp_exc      <= 1'b0;
            rsp_exccode  <= '0;
            rsp_refill   <= 1'b0;
            rsp_paddr    <= '0;
            rsp_cache    <= '0;
            req_ready    <= 1'b0;
            if (user_mode && req_vaddr[VA_W-1]) begin
              rsp_exc     <= 1'b1;
              rsp_exccode <= req_store ? EXC_ADES : EXC_ADEL;
              rsp_valid   <= 1'b1;
              state       <= RESP;
            end else if (req_vaddr[VA_W-1:VA_W-SEG_W] == SEG_KSEG0) begin
              rsp_paddr <= {SEG_W'(0), req_vaddr[VA_W-SEG_W-1:0]};
              rsp_cache <= k0_cca;
              rsp_valid <= 1'b1;
              state     <= RESP;
            end else if (req_vaddr[VA_W-1:VA_W-SEG_W] == SEG_KSEG1) begin
              rsp_paddr <= {SEG_W'(0), req_vaddr[VA_W-SEG_W-1:0]};
              rsp_cache <= CCA_UNCACHED;
              rsp_valid <= 1'b1;
              state     <= RESP;
            end else if (utlb_hit) begin
              rsp_paddr <= {utlb_pfn, req_vaddr[VA_W-PFN_W-1:0]};
              rsp_cache <= utlb_cca;
              if (req_store && !utlb_d) begin
                rsp_exc     <= 1'b1;
                rsp_exccode <= EXC_MOD;
              end
              rsp_valid <= 1'b1;
              state     <= RESP;
            end else begin
              tlb_vaddr <= req_vaddr;
              state     <= LOOKUP;
            end
          end
        end
        LOOKUP: begin
          rsp_paddr <= tlb_paddr;
          rsp_cache <= tlb_c;
          if (!tlb_hit) begin
            rsp_exc     <= 1'b1;
            rsp_exccode <= store_q ? EXC_TLBS : EXC_TLBL;
            rsp_refill  <= 1'b1;
          end else if (!tlb_v) begin
            rsp_exc     <= 1'b1;
            rsp_exccode <= store_q ? EXC_TLBS : EXC_TLBL;
          end else if (store_q && !tlb_d) begin
            rsp_exc     <= 1'b1;
            rsp_exccode <= EXC_MOD;
          end
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          rsp_valid <= 1'b0;
          req_ready <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule
